// File: rtl/mc_main_cntl.sv
// rtl/mc_main_cntl.sv - multicycle main control FSM for the MIPS core
//
// Sequences the datapath through fetch, decode, execute, memory and
// write-back cycles from the IR opcode, and counts retired instructions.
//
// Ports:
//   iClk, iReset      clock, asynchronous active-high reset
//   iOpcode[5:0]      IR[31:26]
//   iMemReady         memory finished the current access this cycle
//   oPCWrite .. oRegDst, oPCSource, oALUSrcB, oALUOp   datapath controls
//   oIllegalOp        one-cycle pulse in DECODE on an unknown opcode
//   oState[3:0]       current state code (debug)
//   oInstCount[15:0]  retired instruction count, wraps
module mc_main_cntl (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [5:0]  iOpcode,
  input  logic        iMemReady,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic        oIorD,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oMemtoReg,
  output logic        oIRWrite,
  output logic        oALUSrcA,
  output logic        oRegWrite,
  output logic        oRegDst,
  output logic [1:0]  oPCSource,
  output logic [1:0]  oALUSrcB,
  output logic [1:0]  oALUOp,
  output logic        oIllegalOp,
  output logic [3:0]  oState,
  output logic [15:0] oInstCount
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IDLE   = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] inst_count_q, inst_count_d;
  logic        retire;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q      <= ST_IDLE;
      inst_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      inst_count_q <= inst_count_d;
    end
  end

  always_comb begin
    state_d      = ST_FETCH;
    retire       = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oMemtoReg    = 1'b0;
    oIRWrite     = 1'b0;
    oALUSrcA     = 1'b0;
    oRegWrite    = 1'b0;
    oRegDst      = 1'b0;
    oPCSource    = 2'b00;
    oALUSrcB     = 2'b00;
    oALUOp       = 2'b00;
    oIllegalOp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = 2'b01;
        // IR and PC+4 are only captured once the instruction word is valid.
        oIRWrite = iMemReady;
        oPCWrite = iMemReady;
        state_d  = iMemReady ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively here: PC + (imm << 2).
        oALUSrcB = 2'b11;
        case (iOpcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default: begin
            oIllegalOp = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
        if (iOpcode == OP_LW) begin
          state_d = ST_MEMRD;
        end else if (iOpcode == OP_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEMRD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        state_d  = iMemReady ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 1'b1;
        retire    = 1'b1;
      end
      ST_MEMWR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        retire    = iMemReady;
        state_d   = iMemReady ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        oALUSrcA = 1'b1;
        oALUOp   = 2'b10;
        state_d  = ST_RWB;
      end
      ST_RWB: begin
        oRegWrite = 1'b1;
        oRegDst   = 1'b1;
        retire    = 1'b1;
      end
      ST_BRANCH: begin
        oALUSrcA     = 1'b1;
        oALUOp       = 2'b01;
        oPCWriteCond = 1'b1;
        oPCSource    = 2'b01;
        retire       = 1'b1;
      end
      ST_JUMP: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'b10;
        retire    = 1'b1;
      end
      default: begin
        // Unreachable codes recover to FETCH with all controls low.
        state_d = ST_FETCH;
      end
    endcase

    inst_count_d = retire ? inst_count_q + 16'd1 : inst_count_q;
  end

  assign oState     = state_q;
  assign oInstCount = inst_count_q;

endmodule

// File: doc/mc_main_cntl.md
# mc_main_cntl

Multicycle main control FSM for the MIPS core. It decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back cycles. It drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU control stage. It stalls on memory states until the memory reports ready, and it keeps a retired-instruction counter.

## Interface
- No parameters. Opcodes are fixed: R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02.
- iClk  input  1  single clock; all state updates on rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iOpcode  input  6  IR[31:26]; stable from the cycle after FETCH completes.
- iMemReady  input  1  memory has completed the current read or write this cycle.
- oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg, oIRWrite, oALUSrcA, oRegWrite, oRegDst  output  1 each  datapath controls.
- oPCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- oALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- oALUOp  output  2  00 = add, 01 = sub, 10 = R-format funct decode.
- oIllegalOp  output  1  one-cycle pulse on an unknown opcode.
- oState  output  4  current state code, for debug.
- oInstCount  output  16  count of retired instructions; wraps.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IDLE 15. Other codes are unreachable; if entered, the next state is FETCH.
- Outputs are decoded from state only, except that FETCH write enables are qualified by iMemReady. Any output not listed for a state is 0.
  - IDLE: all 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite both equal iMemReady.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- Transitions:
  - IDLE → FETCH.
  - FETCH → DECODE if iMemReady, else stay in FETCH.
  - DECODE → MEMADR for LW or SW, EXEC for R-type, BRANCH for BEQ, JUMP for J, else FETCH with oIllegalOp=1 in the DECODE cycle.
  - MEMADR → MEMRD for LW, MEMWR for SW. Opcode is re-read here and is guaranteed stable.
  - MEMRD → MEMWB if iMemReady, else stay.
  - MEMWR → FETCH if iMemReady, else stay.
  - EXEC → RWB.
  - MEMWB, RWB, BRANCH, JUMP → FETCH.
- Retire: oInstCount increments by 1 on the clock edge leaving MEMWB, RWB, BRANCH or JUMP, and on the edge leaving MEMWR with iMemReady=1. Illegal opcodes are not counted. 16'hFFFF + 1 → 16'h0000.

## Timing
- Reset (async, immediate, independent of iClk):
  - state = IDLE, oState = 4'hF, oInstCount = 0, every control output = 0.
  - On the first rising edge after iReset falls, the state enters FETCH.
- Reset asserted mid-instruction aborts the instruction: enables drop to 0 combinationally and the count is unchanged from its reset value (0).
- Cycles from FETCH entry back to FETCH entry, with iMemReady constantly 1:
  - R-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - J: 3.
  - Illegal opcode: 2.
- Each cycle iMemReady is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held constant during the stall, and IRWrite/PCWrite stay 0.
- iMemReady is ignored in every other state.
- oIllegalOp is high for exactly one cycle and is never asserted in any other state.

## Test plan
- Reset and idle: assert iReset mid-EXEC → oState=4'hF and all outputs 0 the same cycle. Release → FETCH on the next edge, oMemRead=1, oALUSrcB=01.
- R-type with iOpcode=6'h00 and iMemReady=1 → state sequence 0,1,6,7,0. oALUOp=10 in EXEC, oRegWrite=oRegDst=1 in RWB, oInstCount 0→1.
- LW with iMemReady low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. oIorD=1 throughout MEMRD, oMemtoReg=1 in MEMWB, 7 cycles total.
- SW, BEQ and J back to back → SW 0,1,2,5,0; BEQ 0,1,8,0 with oALUOp=01 and oPCWriteCond=1; J 0,1,9,0 with oPCSource=10. oInstCount advances by 3.
- FETCH stall of 3 cycles → oIRWrite=oPCWrite=0 during the stall and 1 only in the ready cycle. Illegal iOpcode=6'h3F → oIllegalOp pulses once in DECODE, next state FETCH, count unchanged.
- Counter wrap: preload via 65535 J instructions, or a force in the bench, then retire 1 more → oInstCount=16'h0000.
